// File: rtl/pio_pkg.sv
// Register map and edge-type encodings shared by the Avalon PIO block.
// Constants only; no logic, no latency, no flow control.
package pio_pkg;

    localparam logic [2:0] ADDR_DATA    = 3'd0;
    localparam logic [2:0] ADDR_OUTSET  = 3'd1;
    localparam logic [2:0] ADDR_OUTCLR  = 3'd2;
    localparam logic [2:0] ADDR_IRQMASK = 3'd3;
    localparam logic [2:0] ADDR_EDGECAP = 3'd4;
    localparam logic [2:0] ADDR_OUTREAD = 3'd5;

    localparam int EDGE_RISING  = 0;
    localparam int EDGE_FALLING = 1;
    localparam int EDGE_ANY     = 2;

endpackage

// File: rtl/pio_edge_capture.sv
// Input synchroniser, per-bit edge detect and sticky write-1-to-clear edge capture register.
// in_sync lags in_port by SYNC_STAGES cycles, edge_cap one more; no backpressure, clear is a single-cycle strobe.
module pio_edge_capture
    import pio_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int EDGE_TYPE   = EDGE_RISING,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_port,
    input  logic             clr_vld,
    input  logic [WIDTH-1:0] clr_dat,
    output logic [WIDTH-1:0] in_sync,
    output logic [WIDTH-1:0] edge_cap
);

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] in_prev;
    logic [WIDTH-1:0] edge_det;
    logic [WIDTH-1:0] clr_mask;
    logic [WIDTH-1:0] edge_cap_nxt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= in_port;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign in_sync = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            in_prev <= '0;
        end else begin
            in_prev <= in_sync;
        end
    end

    generate
        if (EDGE_TYPE == EDGE_FALLING) begin : g_falling
            assign edge_det = ~in_sync & in_prev;
        end else if (EDGE_TYPE == EDGE_ANY) begin : g_any
            assign edge_det = in_sync ^ in_prev;
        end else begin : g_rising
            assign edge_det = in_sync & ~in_prev;
        end
    endgenerate

    // OR-ing the new edges in after the clear makes a same-cycle edge win.
    always_comb begin
        clr_mask     = clr_vld ? clr_dat : '0;
        edge_cap_nxt = (edge_cap & ~clr_mask) | edge_det;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            edge_cap <= '0;
        end else begin
            edge_cap <= edge_cap_nxt;
        end
    end

endmodule

// File: rtl/avalon_pio_ctrl.sv
// Avalon-MM PIO slave: output register with atomic set/clear, synchronised input with edge capture and masked irq.
// Zero-wait-state combinational reads, writes take effect at the strobe edge; the slave never stalls the bus.
module avalon_pio_ctrl
    import pio_pkg::*;
#(
    parameter int               WIDTH       = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0,
    parameter int               EDGE_TYPE   = EDGE_RISING,
    parameter int               SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [WIDTH-1:0] writedata,
    output logic [WIDTH-1:0] readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic [WIDTH-1:0] out_port,
    output logic             irq
);

    logic             wr;
    logic [WIDTH-1:0] data_out;
    logic [WIDTH-1:0] irq_mask;
    logic [WIDTH-1:0] in_sync;
    logic [WIDTH-1:0] edge_cap;
    logic             edge_clr_vld;

    assign wr           = chipselect & ~write_n;
    assign edge_clr_vld = wr && (address == ADDR_EDGECAP);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_out <= RESET_VALUE;
        end else if (wr) begin
            case (address)
                ADDR_DATA:   data_out <= writedata;
                ADDR_OUTSET: data_out <= data_out | writedata;
                ADDR_OUTCLR: data_out <= data_out & ~writedata;
                default:     data_out <= data_out;
            endcase
        end
    end

    assign out_port = data_out;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            irq_mask <= '0;
        end else if (wr && (address == ADDR_IRQMASK)) begin
            irq_mask <= writedata;
        end
    end

    pio_edge_capture #(
        .WIDTH       (WIDTH),
        .EDGE_TYPE   (EDGE_TYPE),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_edge_capture (
        .clk      (clk),
        .reset    (reset),
        .in_port  (in_port),
        .clr_vld  (edge_clr_vld),
        .clr_dat  (writedata),
        .in_sync  (in_sync),
        .edge_cap (edge_cap)
    );

    // Registered so irq is glitch-free on the pin.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            irq <= 1'b0;
        end else begin
            irq <= |(edge_cap & irq_mask);
        end
    end

    always_comb begin
        readdata = '0;
        case (address)
            ADDR_DATA:    readdata = in_sync;
            ADDR_IRQMASK: readdata = irq_mask;
            ADDR_EDGECAP: readdata = edge_cap;
            ADDR_OUTREAD: readdata = data_out;
            default:      readdata = '0;
        endcase
    end

endmodule

// File: tb/tb_avalon_pio_ctrl.sv
// Bench for avalon_pio_ctrl: a rising-edge instance (reset value A5) and an any-edge instance on a shared bus.
module tb_avalon_pio_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] address;
    logic       chipselect;
    logic       write_n;
    logic [7:0] writedata;
    logic [7:0] readdata, readdata2;
    logic [7:0] in_port, in_port2;
    logic [7:0] out_port, out_port2;
    logic       irq, irq2;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_q[$];
    logic [7:0] exp;
    logic [7:0] d1, d2;

    always #5 clk = ~clk;

    avalon_pio_ctrl #(.WIDTH(8), .RESET_VALUE(8'hA5), .EDGE_TYPE(0), .SYNC_STAGES(2)) dut (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(readdata),
        .in_port(in_port), .out_port(out_port), .irq(irq));

    avalon_pio_ctrl #(.WIDTH(8), .RESET_VALUE(8'h00), .EDGE_TYPE(2), .SYNC_STAGES(2)) dut_any (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(readdata2),
        .in_port(in_port2), .out_port(out_port2), .irq(irq2));

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus_write(input logic [2:0] a, input logic [7:0] d);
        @(negedge clk);
        address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
        @(negedge clk);
        chipselect = 1'b0; write_n = 1'b1; writedata = 8'h00;
    endtask

    task automatic bus_read(input logic [2:0] a, output logic [7:0] r1, output logic [7:0] r2);
        address = a; chipselect = 1'b1; write_n = 1'b1;
        #1;
        r1 = readdata; r2 = readdata2;
        chipselect = 1'b0;
    endtask

    task automatic test_reset;
        #2;
        exp_q.push_back(8'hA5); exp = exp_q.pop_front(); checks++;
        if (out_port !== exp) begin errors++; $display("FAIL rst_out_port got %h exp %h", out_port, exp); end
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL rst_irq got %b exp 0", irq); end
        exp_q.push_back(8'h00); exp = exp_q.pop_front(); checks++;
        if (out_port2 !== exp) begin errors++; $display("FAIL rst_out_port2 got %h exp %h", out_port2, exp); end
        checks++;
        if (irq2 !== 1'b0) begin errors++; $display("FAIL rst_irq2 got %b exp 0", irq2); end
        cycles(2);
        reset = 1'b0;
        exp_q.push_back(8'hA5); exp_q.push_back(8'h00); exp_q.push_back(8'h00);
        foreach (exp_q[i]) begin end
        bus_read(3'd5, d1, d2); exp = exp_q.pop_front(); checks++;
        if (d1 !== exp) begin errors++; $display("FAIL rst_outread got %h exp %h", d1, exp); end
        bus_read(3'd3, d1, d2); exp = exp_q.pop_front(); checks++;
        if (d1 !== exp) begin errors++; $display("FAIL rst_irqmask got %h exp %h", d1, exp); end
        bus_read(3'd4, d1, d2); exp = exp_q.pop_front(); checks++;
        if (d1 !== exp) begin errors++; $display("FAIL rst_edgecap got %h exp %h", d1, exp); end
    endtask

    task automatic test_outputs;
        logic [2:0] wa [3] = '{3'd0, 3'd1, 3'd2};
        logic [7:0] wd [3] = '{8'h3C, 8'hC0, 8'h0C};
        logic [7:0] we [3] = '{8'h3C, 8'hFC, 8'hF0};
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(we[i]);
            bus_write(wa[i], wd[i]);
            exp = exp_q.pop_front(); checks++;
            if (out_port !== exp) begin errors++; $display("FAIL out_port_w%0d got %h exp %h", i, out_port, exp); end
            checks++;
            if (out_port2 !== exp) begin errors++; $display("FAIL out_port2_w%0d got %h exp %h", i, out_port2, exp); end
        end
        for (int a = 1; a < 3; a++) begin
            exp_q.push_back(8'h00);
            bus_read(3'(a), d1, d2); exp = exp_q.pop_front(); checks++;
            if (d1 !== exp) begin errors++; $display("FAIL read_wo_addr%0d got %h exp %h", a, d1, exp); end
        end
        exp_q.push_back(8'hF0);
        bus_read(3'd5, d1, d2); exp = exp_q.pop_front(); checks++;
        if (d1 !== exp) begin errors++; $display("FAIL outread got %h exp %h", d1, exp); end
        exp_q.push_back(8'hF0);
        bus_write(3'd6, 8'h00); exp = exp_q.pop_front(); checks++;
        if (out_port !== exp) begin errors++; $display("FAIL undef_write got %h exp %h", out_port, exp); end
        for (int a = 6; a < 8; a++) begin
            exp_q.push_back(8'h00);
            bus_read(3'(a), d1, d2); exp = exp_q.pop_front(); checks++;
            if (d1 !== exp) begin errors++; $display("FAIL undef_read%0d got %h exp %h", a, d1, exp); end
        end
    endtask

    task automatic test_rising;
        @(negedge clk); in_port[2] = 1'b1;
        exp_q.push_back(8'h00); exp_q.push_back(8'h04); exp_q.push_back(8'h00); exp_q.push_back(8'h04);
        cycles(1);
        bus_read(3'd0, d1, d2); exp = exp_q.pop_front(); checks++;
        if (d1 !== exp) begin errors++; $display("FAIL data_lat1 got %h exp %h", d1, exp); end
        cycles(1);
        bus_read(3'd0, d1, d2); exp = exp_q.pop_front(); checks++;
        if (d1 !== exp) begin errors++; $display("FAIL data_lat2 got %h exp %h", d1, exp); end
        bus_read(3'd4, d1, d2); exp = exp_q.pop_front(); checks++;
        if (d1 !== exp) begin errors++; $display("FAIL edgecap_early got %h exp %h", d1, exp); end
        cycles(1);
        bus_read(3'd4, d1, d2); exp = exp_q.pop_front(); checks++;
        if (d1 !== exp) begin errors++; $display("FAIL edgecap_set got %h exp %h", d1, exp); end
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL irq_unmasked got %b exp 0", irq); end
        bus_write(3'd3, 8'h04);
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL irq_mask_same_edge got %b exp 0", irq); end
        cycles(1);
        checks++;
        if (irq !== 1'b1) begin errors++; $display("FAIL irq_masked got %b exp 1", irq); end
    endtask

    task automatic test_clear;
        exp_q.push_back(8'h00);
        bus_write(3'd4, 8'h04);
        bus_read(3'd4, d1, d2); exp = exp_q.pop_front(); checks++;
        if (d1 !== exp) begin errors++; $display("FAIL w1c got %h exp %h", d1, exp); end
        cycles(1);
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL irq_after_clr got %b exp 0", irq); end
        @(negedge clk); in_port[2] = 1'b0; cycles(3);
        in_port[2] = 1'b1; cycles(3);
        exp_q.push_back(8'h04);
        bus_read(3'd4, d1, d2); exp = exp_q.pop_front(); checks++;
        if (d1 !== exp) begin errors++; $display("FAIL reset_up_edgecap got %h exp %h", d1, exp); end
        @(negedge clk); in_port[2] = 1'b0; cycles(3);
        in_port[2] = 1'b1;
        exp_q.push_back(8'h04);
        @(posedge clk); @(posedge clk);
        bus_write(3'd4, 8'h04);
        bus_read(3'd4, d1, d2); exp = exp_q.pop_front(); checks++;
        if (d1 !== exp) begin errors++; $display("FAIL clr_vs_edge got %h exp %h", d1, exp); end
        cycles(1);
        checks++;
        if (irq !== 1'b1) begin errors++; $display("FAIL irq_clr_vs_edge got %b exp 1", irq); end
    endtask

    task automatic test_any_edge;
        @(negedge clk); in_port2[0] = 1'b1; cycles(4);
        exp_q.push_back(8'h00);
        bus_write(3'd4, 8'hFF);
        bus_read(3'd4, d1, d2); exp = exp_q.pop_front(); checks++;
        if (d2 !== exp) begin errors++; $display("FAIL any_cleared got %h exp %h", d2, exp); end
        exp_q.push_back(8'h01);
        @(negedge clk); in_port2[0] = 1'b0; cycles(4);
        bus_read(3'd4, d1, d2); exp = exp_q.pop_front(); checks++;
        if (d2 !== exp) begin errors++; $display("FAIL any_fall got %h exp %h", d2, exp); end
        exp_q.push_back(8'h00);
        bus_write(3'd4, 8'h01);
        bus_read(3'd4, d1, d2); exp = exp_q.pop_front(); checks++;
        if (d2 !== exp) begin errors++; $display("FAIL any_clr2 got %h exp %h", d2, exp); end
        exp_q.push_back(8'h01);
        @(negedge clk); in_port2[0] = 1'b1; cycles(4);
        bus_read(3'd4, d1, d2); exp = exp_q.pop_front(); checks++;
        if (d2 !== exp) begin errors++; $display("FAIL any_rise got %h exp %h", d2, exp); end
        @(negedge clk); in_port[0] = 1'b1; cycles(4);
        bus_write(3'd4, 8'hFF);
        exp_q.push_back(8'h00);
        @(negedge clk); in_port[0] = 1'b0; cycles(4);
        bus_read(3'd4, d1, d2); exp = exp_q.pop_front(); checks++;
        if (d1 !== exp) begin errors++; $display("FAIL rise_ignores_fall got %h exp %h", d1, exp); end
    endtask

    task automatic test_reset_mid;
        exp_q.push_back(8'hFF);
        bus_write(3'd0, 8'hFF); exp = exp_q.pop_front(); checks++;
        if (out_port !== exp) begin errors++; $display("FAIL mid_out_ff got %h exp %h", out_port, exp); end
        bus_write(3'd4, 8'hFF);
        @(negedge clk); in_port = 8'h85; cycles(4);
        exp_q.push_back(8'h81);
        bus_read(3'd4, d1, d2); exp = exp_q.pop_front(); checks++;
        if (d1 !== exp) begin errors++; $display("FAIL mid_edgecap got %h exp %h", d1, exp); end
        bus_write(3'd3, 8'h81); cycles(1);
        checks++;
        if (irq !== 1'b1) begin errors++; $display("FAIL mid_irq got %b exp 1", irq); end
        #2 reset = 1'b1;
        #1;
        exp_q.push_back(8'hA5); exp = exp_q.pop_front(); checks++;
        if (out_port !== exp) begin errors++; $display("FAIL async_out got %h exp %h", out_port, exp); end
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL async_irq got %b exp 0", irq); end
        exp_q.push_back(8'h00); exp_q.push_back(8'h00);
        bus_read(3'd4, d1, d2); exp = exp_q.pop_front(); checks++;
        if (d1 !== exp) begin errors++; $display("FAIL async_edgecap got %h exp %h", d1, exp); end
        bus_read(3'd3, d1, d2); exp = exp_q.pop_front(); checks++;
        if (d1 !== exp) begin errors++; $display("FAIL async_irqmask got %h exp %h", d1, exp); end
        @(negedge clk); reset = 1'b0;
        exp_q.push_back(8'h00); exp_q.push_back(8'h85);
        cycles(2);
        bus_read(3'd4, d1, d2); exp = exp_q.pop_front(); checks++;
        if (d1 !== exp) begin errors++; $display("FAIL post_rst_early got %h exp %h", d1, exp); end
        cycles(1);
        bus_read(3'd4, d1, d2); exp = exp_q.pop_front(); checks++;
        if (d1 !== exp) begin errors++; $display("FAIL post_rst_edge got %h exp %h", d1, exp); end
        for (int a = 0; a < 4; a++) begin
            @(negedge clk);
            address = (a == 3) ? 3'd3 : 3'(a); writedata = 8'h3C; chipselect = 1'b0; write_n = 1'b0;
            @(negedge clk); write_n = 1'b1;
        end
        exp_q.push_back(8'hA5); exp = exp_q.pop_front(); checks++;
        if (out_port !== exp) begin errors++; $display("FAIL nocs_out got %h exp %h", out_port, exp); end
        exp_q.push_back(8'h00);
        bus_read(3'd3, d1, d2); exp = exp_q.pop_front(); checks++;
        if (d1 !== exp) begin errors++; $display("FAIL nocs_irqmask got %h exp %h", d1, exp); end
    endtask

    initial begin
        reset = 1'b1; address = 3'd0; chipselect = 1'b0; write_n = 1'b1;
        writedata = 8'h00; in_port = 8'h00; in_port2 = 8'h00;
        test_reset;
        test_outputs;
        test_rising;
        test_clear;
        test_any_edge;
        test_reset_mid;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_leftover got %0d exp 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout got running exp finished");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "timeout");
    end

endmodule
